// File: rtl/vga_chk_pkg.sv
// Shared types, default 640x480 timing and CRC constants for the VGA timing checker.
package vga_chk_pkg;

  typedef enum logic [1:0] {
    SEEK,
    TRACK,
    LOCKED
  } chk_state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // CRC-16/CCITT over one 16-bit word, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                             input logic [15:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync pin, normalises it to "asserted = 1" and flags leading/trailing edges.
module vga_sync_edge #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic lead,
  output logic trail
);

  logic act_q;
  logic act_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_q    <= 1'b0;
      act_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking so act_prev takes the old act_q, forming a true two-stage pipe.
      act_q    <= pin ^ ACTIVE_LOW;
      act_prev <= act_q;
    end
  end

  assign lead  = act_q & ~act_prev;
  assign trail = ~act_q & act_prev;

endmodule

// File: rtl/vga_timing_checker.sv
// Sink-side VGA timing monitor: locks to the frame structure, flags timing errors, counts lit pixels.
// Define VGA_CHECK_CRC_EN to build the per-frame active-region CRC; otherwise crc is tied to 0.
module vga_timing_checker
  import vga_chk_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2,
  parameter int RGB_W           = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [RGB_W-1:0] rgb,
  input  logic             clear_err,
  output logic             locked,
  output logic             frame_done,
  output logic [18:0]      lit_count,
  output logic [15:0]      frame_count,
  output logic             err_hlen,
  output logic             err_hsync,
  output logic             err_vlen,
  output logic             err_vsync,
  output logic [15:0]      crc
);

  localparam logic [15:0] H_TOT_W  = 16'(timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK));
  localparam logic [15:0] V_TOT_W  = 16'(timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK));
  localparam logic [15:0] H_SYNC_W = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_W = 16'(V_SYNC);
  localparam logic [15:0] H_ACT_LO = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] H_ACT_HI = 16'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [15:0] V_ACT_LO = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] V_ACT_HI = 16'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [8:0]  LOCK_W   = 9'(LOCK_FRAMES);

  logic h_lead, h_trail, v_lead, v_trail;

  vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs_edge (
    .clock(clock), .reset(reset), .pin(hsync), .lead(h_lead), .trail(h_trail)
  );

  vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs_edge (
    .clock(clock), .reset(reset), .pin(vsync), .lead(v_lead), .trail(v_trail)
  );

  chk_state_e       state, state_d;
  logic [7:0]       good, good_d;
  logic [8:0]       good_inc;
  logic             done_d;
  logic [15:0]      hcnt, vline;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [18:0]      lit_acc;
  logic             checking, active;
  logic             e_hlen, e_hsync, e_vlen, e_vsync, any_err;

  // hcnt restarts the cycle after the edge, so a second rgb stage lines pixel j up with hcnt == j.
  assign active = (hcnt >= H_ACT_LO) && (hcnt < H_ACT_HI) &&
                  (vline >= V_ACT_LO) && (vline < V_ACT_HI);

  // vsync edges sit on line starts, so the coincident hsync edge is counted as line one.
  assign checking = (state != SEEK);
  assign e_hlen   = checking && h_lead  && (hcnt  + 16'd1 != H_TOT_W);
  assign e_hsync  = checking && h_trail && (hcnt  + 16'd1 != H_SYNC_W);
  assign e_vlen   = checking && v_lead  && (vline + 16'd1 != V_TOT_W);
  assign e_vsync  = checking && v_trail && (vline + 16'd1 != V_SYNC_W);
  assign any_err  = e_hlen || e_hsync || e_vlen || e_vsync;
  assign good_inc = {1'b0, good} + 9'd1;
  assign locked   = (state == LOCKED);

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    state_d = state;
    good_d  = good;
    done_d  = 1'b0;
    unique case (state)
      SEEK: begin
        if (v_lead) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK, LOCKED: begin
        if (v_lead) begin
          done_d = 1'b1;
          if (any_err) begin
            state_d = TRACK;
            good_d  = '0;
          end else if (good_inc >= LOCK_W) begin
            state_d = LOCKED;
            good_d  = LOCK_W[7:0];
          end else begin
            good_d  = good_inc[7:0];
          end
        end else if (any_err) begin
          state_d = SEEK;
          good_d  = '0;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= SEEK;
      good        <= '0;
      hcnt        <= '0;
      vline       <= '0;
      rgb_q       <= '0;
      rgb_d       <= '0;
      lit_acc     <= '0;
      frame_done  <= 1'b0;
      lit_count   <= '0;
      frame_count <= '0;
      err_hlen    <= 1'b0;
      err_hsync   <= 1'b0;
      err_vlen    <= 1'b0;
      err_vsync   <= 1'b0;
    end else begin
      state      <= state_d;
      good       <= good_d;
      rgb_q      <= rgb;
      rgb_d      <= rgb_q;
      frame_done <= done_d;
      hcnt       <= h_lead ? '0 : hcnt + 16'd1;
      if (v_lead)      vline <= '0;
      else if (h_lead) vline <= vline + 16'd1;
      if (v_lead)
        lit_acc <= '0;
      else if (active && (rgb_d != '0) && (lit_acc != '1))
        lit_acc <= lit_acc + 19'd1;
      if (done_d) begin
        lit_count   <= lit_acc;
        frame_count <= frame_count + 16'd1;
      end
      // A new error in the same cycle as clear_err keeps its flag set.
      err_hlen  <= e_hlen  | (err_hlen  & ~clear_err);
      err_hsync <= e_hsync | (err_hsync & ~clear_err);
      err_vlen  <= e_vlen  | (err_vlen  & ~clear_err);
      err_vsync <= e_vsync | (err_vsync & ~clear_err);
    end
  end

`ifdef VGA_CHECK_CRC_EN
  logic [15:0] crc_acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crc_acc <= CRC_INIT;
      crc     <= '0;
    end else begin
      if (v_lead)      crc_acc <= CRC_INIT;
      else if (active) crc_acc <= crc16_step(crc_acc, 16'(rgb_d));
      if (done_d)      crc     <= crc_acc;
    end
  end
`else
  assign crc = '0;
`endif

endmodule

// File: tb/tb_vga_timing_checker.sv
// Scoreboard bench for vga_timing_checker on a 12x7 raster (H 8/1/2/1, V 4/1/1/1), two-frame lock.
module tb_vga_timing_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [8:0]  rgb = '0;
  logic        clear_err = 1'b0;
  logic        locked, frame_done;
  logic [18:0] lit_count;
  logic [15:0] frame_count, crc;
  logic        err_hlen, err_hsync, err_vlen, err_vsync;

  vga_timing_checker #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2), .RGB_W(9)
  ) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .clear_err(clear_err), .locked(locked), .frame_done(frame_done),
    .lit_count(lit_count), .frame_count(frame_count),
    .err_hlen(err_hlen), .err_hsync(err_hsync), .err_vlen(err_vlen),
    .err_vsync(err_vsync), .crc(crc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [18:0] lit;
    logic [15:0] fc;
    logic [15:0] crc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Bench-side view of the checker: tracking, clean-frame count, frame counter, sticky errors.
  bit          m_track = 0;
  int          m_good = 0;
  logic [15:0] m_fc = '0;
  logic [3:0]  m_err = '0;   // {hlen, hsync, vlen, vsync}
  logic [18:0] prev_lit = '0;
  logic [15:0] prev_crc = '0;
  int          prev_lines = 7;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    for (int i = 0; i < 16; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] exp_crc(input logic [15:0] c);
`ifdef VGA_CHECK_CRC_EN
    return c;
`else
    return 16'h0000 & c;
`endif
  endfunction

  task automatic drive_pix(input bit hs_a, input bit vs_a, input logic [8:0] c);
    @(posedge clock);
    #1;
    hsync = ~hs_a;
    vsync = ~vs_a;
    rgb   = c;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_done"},   32'(frame_done), 32'd0);
    check({tag, "_lit"},    32'(lit_count), 32'd0);
    check({tag, "_fcount"}, 32'(frame_count), 32'd0);
    check({tag, "_errs"},   32'({err_hlen, err_hsync, err_vlen, err_vsync}), 32'd0);
    check({tag, "_crc"},    32'(crc), 32'd0);
  endtask

  task automatic check_status(input int fr);
    string s;
    s = $sformatf("f%0d", fr);
    check({s, "_locked"}, 32'(locked), 32'(m_track && (m_good >= 2)));
    check({s, "_errs"},   32'({err_hlen, err_hsync, err_vlen, err_vsync}), 32'(m_err));
    check({s, "_fcount"}, 32'(frame_count), 32'(m_fc));
  endtask

  // Model of the frame edge: a tracked previous frame must produce frame_done.
  task automatic frame_edge();
    exp_t e;
    if (!m_track) begin
      m_track = 1;
      m_good  = 0;
    end else begin
      m_fc  = m_fc + 16'd1;
      e.lit = prev_lit;
      e.fc  = m_fc;
      e.crc = exp_crc(prev_crc);
      sb.push_back(e);
      if (prev_lines != 7) begin
        m_err[1] = 1'b1;
        m_good   = 0;
      end else begin
        m_good++;
      end
    end
  endtask

  task automatic send_frame(input int fr, input int n_lines, input int long_line,
                            input int wide_line, input int pattern,
                            input int clr_line, input int rst_line);
    logic [18:0] lit;
    logic [15:0] c16;
    logic [8:0]  c;
    int          len, sw;
    bit          act;
    frame_edge();
    lit = '0;
    c16 = 16'hFFFF;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == long_line) ? 13 : 12;
      sw  = (l == wide_line) ? 3 : 2;
      for (int j = 0; j < len; j++) begin
        c   = (pattern == 0) ? 9'h1FF : (((j + l) % 2 == 1) ? 9'h1FF : 9'h000);
        act = (l >= 2) && (l < 6) && (j >= 3) && (j < 11);
        drive_pix(j < sw, l < 1, c);
        clear_err = (l == clr_line) && (j == 0);
        if (act && (c != 0)) lit = lit + 19'd1;
        if (act) c16 = ref_crc(c16, 16'(c));
        if (l == 1 && j == 0) check_status(fr);
        if (l == clr_line && j == 3) begin
          m_err = '0;
          check($sformatf("f%0d_clear", fr),
                32'({err_hlen, err_hsync, err_vlen, err_vsync}), 32'd0);
        end
        if (l == rst_line && j == 5) begin
          reset = 1'b0;
          #1;
          check_outputs_zero($sformatf("f%0d_midrst", fr));
          m_track = 0;
          m_good  = 0;
          m_fc    = '0;
          m_err   = '0;
          @(posedge clock);
          #1;
          reset = 1'b1;
        end
      end
    end
    if (long_line >= 0) m_err[3] = 1'b1;
    if (wide_line >= 0) m_err[2] = 1'b1;
    if (long_line >= 0 || wide_line >= 0) begin
      m_track = 0;
      m_good  = 0;
    end
    prev_lit   = lit;
    prev_crc   = c16;
    prev_lines = n_lines;
  endtask

  always @(negedge clock) begin
    if (reset && frame_done) begin : pop_blk
      exp_t e;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("done%0d_lit", e.fc),    32'(lit_count),   32'(e.lit));
        check($sformatf("done%0d_fcount", e.fc), 32'(frame_count), 32'(e.fc));
        check($sformatf("done%0d_crc", e.fc),    32'(crc),         32'(e.crc));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (5) drive_pix(0, 0, 9'h000);

    // Clean lock-up: frame_done from edge 2, locked after edge 3.
    for (int f = 1; f <= 5; f++) send_frame(f, 7, -1, -1, 0, -1, -1);
    // Lengthened line drops lock; three clean edges relock.
    send_frame(6, 7, 3, -1, 0, -1, -1);
    for (int f = 7; f <= 9; f++) send_frame(f, 7, -1, -1, 0, -1, -1);
    // Wide hsync pulse, then clear_err while relocking.
    send_frame(10, 7, -1, 4, 0, -1, -1);
    send_frame(11, 7, -1, -1, 0, 2, -1);
    for (int f = 12; f <= 13; f++) send_frame(f, 7, -1, -1, 0, -1, -1);
    // Eight-line frame: vlen error at its closing edge, still tracking.
    send_frame(14, 8, -1, -1, 0, -1, -1);
    for (int f = 15; f <= 17; f++) send_frame(f, 7, -1, -1, 0, -1, -1);
    // Reset mid-frame while locked, then relock.
    send_frame(18, 7, -1, -1, 0, -1, 3);
    for (int f = 19; f <= 21; f++) send_frame(f, 7, -1, -1, 0, -1, -1);
    // Checkerboard frame: 16 lit pixels and a reference CRC.
    send_frame(22, 7, -1, -1, 1, -1, -1);
    send_frame(23, 7, -1, -1, 0, -1, -1);

    repeat (6) drive_pix(0, 0, 9'h000);
    check("pending_done", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_checker.md
Name: vga_timing_checker

Overview:
- Sink-side monitor for the VGA output interface driven by our game-of-life display blocks.
- Samples hsync, vsync and pixel colour bits, then locks to the frame structure.
- Checks every line and frame against parameterised timing, and reports sticky errors, a per-frame lit-pixel count and a frame counter.
- Used in-bench as a self-checking replacement for manual waveform inspection, and synthesisable for on-chip loopback tests.

Parameters:
H_ACTIVE, 640, visible clocks per line
H_FRONT, 16, front-porch clocks
H_SYNC, 96, hsync pulse width in clocks
H_BACK, 48, back-porch clocks
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, front-porch lines
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, back-porch lines
SYNC_ACTIVE_LOW, 1, 1 means both syncs are asserted low
LOCK_FRAMES, 2, consecutive clean frames required for lock
RGB_W, 9, colour bus width

Ports:
clock  in  1  pixel-rate clock, rising edge
reset  in  1  asynchronous, active-low reset
hsync  in  1  horizontal sync from the display block
vsync  in  1  vertical sync from the display block
rgb  in  RGB_W  concatenated colour bits
clear_err  in  1  synchronous clear of all err_* flags
locked  out  1  timing locked
frame_done  out  1  one-cycle pulse; lit_count/crc valid this cycle
lit_count  out  19  non-zero-rgb pixels in the last completed frame
frame_count  out  16  completed frames, wraps at 0xFFFF->0
err_hlen, err_hsync, err_vlen, err_vsync  out  1 each  sticky error flags
crc  out  16  active-region CRC (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state SEEK; all counters 0.
- Inputs pass through one register stage, followed by edge detection on the asserted polarity. Every decision lags the pins by 1 clock.
- hcnt: cleared to 0 on the hsync leading edge, otherwise increments each clock.
- vline: cleared to 0 on the vsync leading edge, otherwise increments on each hsync leading edge. If both edges occur in the same cycle, vsync wins and vline is set to 0.
- Checks, applied in TRACK and LOCKED only:
  - err_hlen: on an hsync leading edge, hcnt+1 must equal H_TOTAL (sum of the four H parameters).
  - err_hsync: on an hsync trailing edge, asserted clock count must equal H_SYNC.
  - err_vlen: on a vsync leading edge, hsync leading edges since the previous vsync leading edge must equal V_TOTAL.
  - err_vsync: on a vsync trailing edge, hsync leading edges during assertion must equal V_SYNC.
- Active pixel window: hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and vline in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE). Each active pixel with rgb != 0 increments the running lit accumulator; it saturates at all ones.
- FSM states and transitions:
  - SEEK: the next vsync leading edge goes to TRACK, with good=0 and accumulators cleared. No frame_done is issued.
  - TRACK, on a vsync leading edge:
    - Issue frame_done; latch lit_count and crc; increment frame_count; clear accumulators.
    - If the frame was clean, good++. Reaching LOCK_FRAMES goes to LOCKED and sets locked=1.
  - LOCKED: same per-frame actions as TRACK.
  - Any check failure in TRACK or LOCKED: set the flag, force locked=0 and good=0.
    - Failure on a vsync leading edge: stay in or go to TRACK; that edge is still a valid frame start and frame_done is still issued.
    - Any other failure: go to SEEK.
- clear_err clears the flags next clock. If a new error occurs in the same cycle, the error wins.
- Reset asserted mid-frame: immediate return to reset values.

Optional Feature:
- Macro VGA_CHECK_CRC_EN.
- When defined: CRC-16/CCITT (poly 0x1021, init 0xFFFF) over the rgb zero-padded to 16 bits, for each active pixel in raster order. The result is latched to crc on frame_done.
- When undefined: no CRC logic is built and crc is constant 0.

Decomposition:
- Package vga_chk_pkg holds:
  - the state enum (SEEK, TRACK, LOCKED);
  - default 640x480 timing constants;
  - CRC polynomial and initial value;
  - a function computing H_TOTAL/V_TOTAL.
- Sub-module vga_sync_edge: input register, polarity normalisation, leading/trailing pulses; one instance each for hsync and vsync.

Test Plan:
All scenarios use small timing: H 8/1/2/1 (H_TOTAL 12) and V 4/1/1/1 (V_TOTAL 7), with LOCK_FRAMES=2.
- Clean stream, 4 frames, all pixels lit -> frame_done on vsync edges 2-4; lit_count=32 each; locked=1 after edge 3; frame_count=3; no errors.
- One line lengthened to 13 clocks in frame 3 after lock -> err_hlen=1, locked=0, SEEK. After 3 further clean frames, locked=1 again.
- hsync pulse 3 clocks on one line -> err_hsync=1. Assert clear_err -> flag 0 next clock while relock proceeds.
- Frame with 8 lines -> err_vlen=1 on that edge; frame_done still pulses; FSM stays in TRACK.
- Reset pulsed mid-frame while locked -> all outputs 0 immediately. Relock after 3 vsync edges.
- With VGA_CHECK_CRC_EN, checkerboard rgb=0x1FF/0 -> lit_count=16; crc matches the bench reference model. Without the macro, crc=0.
